ram_blk_cfg_writer: RTL and testbench
=====================================

Name: ram_blk_cfg_writer

Overview:
- Producer side of the table RAM write port (addra/dina/ena/wea).
- Takes a control-path config stream (valid/ready, last-flagged beats) and writes consecutive table entries.
- Each packet is one header beat (start address, word count) followed by data beats.
- The datapath reads the RAM asynchronously on port b; this block owns port a exclusively.

Parameters:
- ADDR_BITS, 5, RAM address width; table depth is 2^ADDR_BITS.
- DATA_BITS, 32, RAM word width and config beat width. Must be >= 16+ADDR_BITS.

Ports:
- clk  in  1  single clock for stream and RAM write port.
- aresetn  in  1  asynchronous active-low reset.
- s_cfg_tdata  in  DATA_BITS  config beat.
- s_cfg_tvalid  in  1  beat valid.
- s_cfg_tlast  in  1  last beat of packet.
- s_cfg_tready  out  1  beat accept.
- cfg_hold  in  1  datapath freeze request; blocks acceptance.
- addra  out  ADDR_BITS  RAM write address.
- dina  out  DATA_BITS  RAM write data.
- ena  out  1  RAM port enable.
- wea  out  1  RAM write enable.
- pkt_done  out  1  one-cycle pulse when a packet completes cleanly.
- err_short  out  1  one-cycle pulse: tlast before count words were written.
- err_long  out  1  one-cycle pulse: count reached with no tlast; rest of packet dropped.
- err_hdr  out  1  one-cycle pulse: count==0, or header beat carries tlast.
- wr_count  out  16  total words written since reset; saturates at 0xFFFF.

Behaviour:
- Beat accepted when s_cfg_tvalid && s_cfg_tready.
- s_cfg_tready = !cfg_hold && reset deasserted (registered release: low on the first cycle after reset). tvalid does not gate tready.
- Header layout: tdata[15:0] = count N; tdata[16+ADDR_BITS-1:16] = start address; higher bits ignored.
- FSM states S_HDR (reset), S_DATA, S_DROP.
- S_HDR, accepted beat:
  - N==0 or tlast=1: pulse err_hdr. Next state is S_HDR if tlast, else S_DROP.
  - Otherwise: load addr_ptr=start, remaining=N, go S_DATA.
- S_DATA, accepted beat:
  - Issue write of tdata at addr_ptr; addr_ptr increments mod 2^ADDR_BITS (wraps 31->0 at default); remaining decrements.
  - remaining==1 && tlast: pulse pkt_done, go S_HDR.
  - remaining==1 && !tlast: pulse err_long, go S_DROP.
  - remaining>1 && tlast: pulse err_short, go S_HDR. Words already written stay written.
- S_DROP: accept and discard beats; on tlast go S_HDR. No writes.
- Write port timing:
  - Registered, latency 1: beat accepted in cycle t gives ena=wea=1 with addra/dina valid in cycle t+1.
  - ena=wea=0 in every cycle without a write.
  - addra/dina hold their last value when idle.
  - Back-to-back beats give back-to-back writes.
- Pulse timing: pkt_done and err_* pulse in cycle t+1, aligned with the final write.
- cfg_hold asserted mid-packet: tready drops the same cycle, FSM and counters freeze, the packet resumes on release. A write already registered still completes.
- wr_count increments once per issued write and saturates.
- Reset values, applied asynchronously (mid-packet too): s_cfg_tready=0, addra=0, dina=0, ena=0, wea=0, pkt_done=0, all err_*=0, wr_count=0, FSM=S_HDR, addr_ptr=0, remaining=0. Any partial packet is abandoned; the next accepted beat is treated as a header.

Decomposition:
- Shared package ram_cfg_pkg holds:
  - FSM state encoding (S_HDR=2'd0, S_DATA=2'd1, S_DROP=2'd2).
  - Header field constants HDR_CNT_LSB=0, HDR_CNT_W=16, HDR_ADDR_LSB=16.
- Single module. No sub-module needed; the writer drives a ram_blk instance at top level.

Test Plan:
- Header {addr=3,N=2}, data 0xAAAA0001, 0xAAAA0002 (tlast) -> writes ram[3], ram[4], one per cycle at t+1; pkt_done pulses with the second write; wr_count=2.
- Header {addr=30,N=4}, 4 data beats, last with tlast -> addra sequence 30, 31, 0, 1; pkt_done pulses.
- Header {addr=0,N=3}, 2 data beats, second with tlast -> two writes; err_short pulses; the next beat is parsed as a header.
- Header {addr=8,N=1}, 3 data beats, tlast on the third -> one write to addr 8; err_long pulses; beats 2–3 dropped; wea stays 0.
- Header N=0 without tlast, then 2 beats with tlast on the second -> err_hdr pulses once, no writes. Then a valid header {addr=5,N=1} plus 1 beat -> write ram[5].
- cfg_hold toggled mid-packet, then aresetn asserted mid-packet -> tready=0 while held and writes resume in order on release; reset forces all outputs to 0 and a fresh packet {addr=2,N=1} writes ram[2].

Source files
------------

// File: rtl/ram_cfg_pkg.sv
// Shared definitions for the config-stream table writer: FSM encoding and
// header field positions.
package ram_cfg_pkg;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } cfg_state_e;

  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = 16;
  localparam int HDR_ADDR_LSB = 16;

endpackage

// File: rtl/ram_blk_cfg_writer.sv
// Turns a last-flagged config stream (header + data beats) into registered
// writes on port a of the table RAM, with per-packet status pulses.
module ram_blk_cfg_writer
  import ram_cfg_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [DATA_BITS-1:0] s_cfg_tdata,
  input  logic                 s_cfg_tvalid,
  input  logic                 s_cfg_tlast,
  output logic                 s_cfg_tready,
  input  logic                 cfg_hold,
  output logic [ADDR_BITS-1:0] addra,
  output logic [DATA_BITS-1:0] dina,
  output logic                 ena,
  output logic                 wea,
  output logic                 pkt_done,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_hdr,
  output logic [15:0]          wr_count
);

  cfg_state_e             state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_ptr_q, addr_ptr_d;
  logic [15:0]            remaining_q, remaining_d;
  logic                   rdy_q;
  logic [ADDR_BITS-1:0]   addra_q, addra_d;
  logic [DATA_BITS-1:0]   dina_q, dina_d;
  logic                   wr_q, wr_d;
  logic                   pkt_done_q, pkt_done_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   err_hdr_q, err_hdr_d;
  logic [15:0]            wr_count_q, wr_count_d;

  logic                   accept_s;
  logic [HDR_CNT_W-1:0]   hdr_cnt_s;
  logic [ADDR_BITS-1:0]   hdr_addr_s;

  // tready is released one cycle after reset; hold gates it combinationally
  assign s_cfg_tready = rdy_q & ~cfg_hold;
  assign accept_s     = s_cfg_tvalid & s_cfg_tready;
  assign hdr_cnt_s    = s_cfg_tdata[HDR_CNT_LSB +: HDR_CNT_W];
  assign hdr_addr_s   = s_cfg_tdata[HDR_ADDR_LSB +: ADDR_BITS];

  assign addra     = addra_q;
  assign dina      = dina_q;
  assign ena       = wr_q;
  assign wea       = wr_q;
  assign pkt_done  = pkt_done_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign err_hdr   = err_hdr_q;
  assign wr_count  = wr_count_q;

  // Packet parser: next state, pointers, write request and status pulses
  always_comb begin
    state_d     = state_q;
    addr_ptr_d  = addr_ptr_q;
    remaining_d = remaining_q;
    addra_d     = addra_q;
    dina_d      = dina_q;
    wr_d        = 1'b0;
    pkt_done_d  = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_hdr_d   = 1'b0;
    if (accept_s) begin
      case (state_q)
        S_HDR: begin
          if ((hdr_cnt_s == 16'd0) || s_cfg_tlast) begin
            err_hdr_d = 1'b1;
            state_d   = s_cfg_tlast ? S_HDR : S_DROP;
          end else begin
            addr_ptr_d  = hdr_addr_s;
            remaining_d = hdr_cnt_s;
            state_d     = S_DATA;
          end
        end
        S_DATA: begin
          wr_d        = 1'b1;
          addra_d     = addr_ptr_q;
          dina_d      = s_cfg_tdata;
          addr_ptr_d  = addr_ptr_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            if (s_cfg_tlast) begin
              pkt_done_d = 1'b1;
              state_d    = S_HDR;
            end else begin
              err_long_d = 1'b1;
              state_d    = S_DROP;
            end
          end else if (s_cfg_tlast) begin
            err_short_d = 1'b1;
            state_d     = S_HDR;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DROP: begin
          if (s_cfg_tlast) begin
            state_d = S_HDR;
          end else begin
            state_d = S_DROP;
          end
        end
        default: begin
          state_d = S_HDR;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Saturating count of issued writes
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_d && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // State, pointer and registered write-port / status outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_HDR;
      addr_ptr_q  <= '0;
      remaining_q <= 16'd0;
      rdy_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      wr_q        <= 1'b0;
      pkt_done_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_hdr_q   <= 1'b0;
      wr_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      remaining_q <= remaining_d;
      rdy_q       <= 1'b1;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      wr_q        <= wr_d;
      pkt_done_q  <= pkt_done_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_hdr_q   <= err_hdr_d;
      wr_count_q  <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_ram_blk_cfg_writer.sv
// Randomized bench for ram_blk_cfg_writer: packets are expanded into beats with
// their expected per-beat effects, then checked cycle by cycle.
module tb_ram_blk_cfg_writer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_cfg_tdata = 32'd0;
  logic        s_cfg_tvalid = 1'b0;
  logic        s_cfg_tlast = 1'b0;
  logic        s_cfg_tready;
  logic        cfg_hold = 1'b0;
  logic [4:0]  addra;
  logic [31:0] dina;
  logic        ena, wea, pkt_done, err_short, err_long, err_hdr;
  logic [15:0] wr_count;

  ram_blk_cfg_writer #(.ADDR_BITS(5), .DATA_BITS(32)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tvalid(s_cfg_tvalid),
    .s_cfg_tlast(s_cfg_tlast), .s_cfg_tready(s_cfg_tready),
    .cfg_hold(cfg_hold),
    .addra(addra), .dina(dina), .ena(ena), .wea(wea),
    .pkt_done(pkt_done), .err_short(err_short), .err_long(err_long),
    .err_hdr(err_hdr), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        wr;
    logic [4:0]  addr;
    logic        done;
    logic        shrt;
    logic        lng;
    logic        hdr;
  } beat_t;

  beat_t beatq[$];

  int checks = 0;
  int errors = 0;

  // expected outputs for the next sample point
  logic        exp_wr = 1'b0, exp_done = 1'b0, exp_shrt = 1'b0, exp_lng = 1'b0, exp_hdr = 1'b0;
  logic [4:0]  exp_addr = 5'd0;
  logic [31:0] exp_data = 32'd0;
  int          wr_cnt_m = 0;
  logic        rdy_en_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t new_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l; b.wr = 1'b0; b.addr = 5'd0;
    b.done = 1'b0; b.shrt = 1'b0; b.lng = 1'b0; b.hdr = 1'b0;
    return b;
  endfunction

  // Expand one packet: header {start,n} followed by len data beats.
  task automatic gen_pkt(input int start, input int n, input int len, input logic [31:0] dbase);
    beat_t       b;
    logic [10:0] up;
    logic [31:0] d;
    up = 11'($urandom);
    b = new_beat({up, 5'(start), 16'(n)}, (len == 0));
    if (n == 0 || len == 0) begin
      b.hdr = 1'b1;
      beatq.push_back(b);
      for (int i = 0; i < len; i++) beatq.push_back(new_beat($urandom, (i == len - 1)));
    end else begin
      beatq.push_back(b);
      for (int i = 0; i < len; i++) begin
        d = (dbase == 32'd0) ? $urandom : dbase + 32'(i + 1);
        b = new_beat(d, (i == len - 1));
        if (i < n) begin
          b.wr   = 1'b1;
          b.addr = 5'((start + i) % 32);
          if (i == n - 1 && len == n) b.done = 1'b1;
          if (i == n - 1 && len > n)  b.lng  = 1'b1;
        end
        if (i == len - 1 && len < n) b.shrt = 1'b1;
        beatq.push_back(b);
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    check_eq({pfx, "ena"},       {31'd0, ena},       {31'd0, exp_wr});
    check_eq({pfx, "wea"},       {31'd0, wea},       {31'd0, exp_wr});
    check_eq({pfx, "addra"},     {27'd0, addra},     {27'd0, exp_addr});
    check_eq({pfx, "dina"},      dina,               exp_data);
    check_eq({pfx, "pkt_done"},  {31'd0, pkt_done},  {31'd0, exp_done});
    check_eq({pfx, "err_short"}, {31'd0, err_short}, {31'd0, exp_shrt});
    check_eq({pfx, "err_long"},  {31'd0, err_long},  {31'd0, exp_lng});
    check_eq({pfx, "err_hdr"},   {31'd0, err_hdr},   {31'd0, exp_hdr});
    check_eq({pfx, "wr_count"},  {16'd0, wr_count},  32'(wr_cnt_m));
  endtask

  task automatic clear_model();
    beatq.delete();
    exp_wr = 1'b0; exp_done = 1'b0; exp_shrt = 1'b0; exp_lng = 1'b0; exp_hdr = 1'b0;
    exp_addr = 5'd0; exp_data = 32'd0; wr_cnt_m = 0; rdy_en_m = 1'b0;
  endtask

  // One clock: check last cycle's results, present a beat, predict its effect.
  task automatic run_cycle(input int vpct, input int hpct);
    logic  acc;
    beat_t b;
    @(negedge clk);
    check_outputs("");
    cfg_hold = ($urandom_range(0, 99) < hpct);
    if (beatq.size() > 0 && $urandom_range(0, 99) < vpct) begin
      s_cfg_tvalid = 1'b1;
      s_cfg_tdata  = beatq[0].data;
      s_cfg_tlast  = beatq[0].last;
    end else begin
      s_cfg_tvalid = 1'b0;
      s_cfg_tdata  = $urandom;
      s_cfg_tlast  = 1'($urandom);
    end
    #1;
    check_eq("tready", {31'd0, s_cfg_tready}, {31'd0, rdy_en_m && !cfg_hold});
    acc = s_cfg_tvalid && rdy_en_m && !cfg_hold;
    exp_wr = 1'b0; exp_done = 1'b0; exp_shrt = 1'b0; exp_lng = 1'b0; exp_hdr = 1'b0;
    if (acc) begin
      b = beatq.pop_front();
      exp_wr = b.wr; exp_done = b.done; exp_shrt = b.shrt; exp_lng = b.lng; exp_hdr = b.hdr;
      if (b.wr) begin
        exp_addr = b.addr;
        exp_data = b.data;
        if (wr_cnt_m < 65535) wr_cnt_m++;
      end
    end
    rdy_en_m = 1'b1;
  endtask

  task automatic drain(input int vpct, input int hpct, input int budget);
    int cyc = 0;
    while (beatq.size() > 0 && cyc < budget) begin
      run_cycle(vpct, hpct);
      cyc++;
    end
    check_eq("drain_left", 32'(beatq.size()), 32'd0);
    beatq.delete();
    run_cycle(0, 0);
    run_cycle(0, 0);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    aresetn = 1'b0;
    s_cfg_tvalid = 1'b0;
    cfg_hold = 1'b0;
    clear_model();
    #1;
    check_outputs("rst_");
    check_eq("rst_tready", {31'd0, s_cfg_tready}, 32'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    #1;
    check_eq("rel_tready", {31'd0, s_cfg_tready}, 32'd0);
    rdy_en_m = 1'b1;
  endtask

  initial begin
    int n, len;
    clear_model();
    #1;
    check_outputs("init_");
    check_eq("init_tready", {31'd0, s_cfg_tready}, 32'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    #1;
    check_eq("rel_tready", {31'd0, s_cfg_tready}, 32'd0);
    rdy_en_m = 1'b1;

    // directed packets from the plan, first with no gaps then with hold
    gen_pkt(3, 2, 2, 32'hAAAA0000);
    drain(100, 0, 100);
    gen_pkt(30, 4, 4, 32'hBBBB0000);
    gen_pkt(0, 3, 2, 32'hCCCC0000);
    gen_pkt(8, 1, 3, 32'hDDDD0000);
    gen_pkt(5, 0, 2, 32'd0);
    gen_pkt(5, 1, 1, 32'hEEEE0000);
    gen_pkt(12, 3, 0, 32'd0);
    drain(80, 25, 400);

    // random packets, including header errors, short and long packets
    for (int p = 0; p < 60; p++) begin
      n   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      len = $urandom_range(0, n + 2);
      gen_pkt($urandom_range(0, 31), n, len, 32'd0);
    end
    drain(70, 20, 4000);

    // asynchronous reset in the middle of a packet with hold toggling
    gen_pkt(10, 6, 6, 32'h12340000);
    for (int c = 0; c < 200 && beatq.size() > 4; c++) run_cycle(80, 30);
    reset_mid();
    gen_pkt(2, 1, 1, 32'h55550000);
    drain(100, 0, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
